// File: rtl/demux_pipe.sv
// demux_pipe: splits one 128-bit enq stream into a zero-latency local
// output and a forward output buffered by a 2-entry circular FIFO.
//
// Ports:
//   CLK, nRST                      clock; async active-high reset
//   in_enq__ENA/_v/__RDY           input message stream
//   out_enq__ENA/_v/__RDY          local messages (dest == NODE_ID)
//   forward_enq__ENA/_v/__RDY      all other messages, FIFO head
//   localCount, fwdCount           wrapping issue counters
module demux_pipe #(
    parameter logic [7:0] NODE_ID = 8'h01,
    parameter int         DEST_HI = 127
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         in_enq__ENA,
    input  logic [127:0] in_enq_v,
    output logic         in_enq__RDY,
    output logic         out_enq__ENA,
    output logic [127:0] out_enq_v,
    input  logic         out_enq__RDY,
    output logic         forward_enq__ENA,
    output logic [127:0] forward_enq_v,
    input  logic         forward_enq__RDY,
    output logic [31:0]  localCount,
    output logic [31:0]  fwdCount
);

    logic [127:0] e0;
    logic [127:0] e1;
    logic         rptr;
    logic         wptr;
    logic [1:0]   fcount;
    logic [31:0]  local_cnt;
    logic [31:0]  fwd_cnt;

    logic         is_local;
    logic         enq;
    logic         deq;

    assign is_local = (in_enq_v[DEST_HI -: 8] == NODE_ID);

    // Ready ignores the payload so the sender never decodes the
    // destination; a full FIFO blocks input even if it drains now.
    assign in_enq__RDY = out_enq__RDY & (fcount != 2'd2) & ~nRST;

    assign out_enq__ENA = in_enq__ENA & is_local & ~nRST;
    assign out_enq_v    = in_enq_v;

    assign enq = in_enq__ENA & ~is_local & ~nRST;
    // No bypass: only entries already stored can drain.
    assign deq = (fcount != 2'd0) & forward_enq__RDY;

    assign forward_enq__ENA = deq;
    assign forward_enq_v    = rptr ? e1 : e0;

    assign localCount = local_cnt;
    assign fwdCount   = fwd_cnt;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            e0        <= '0;
            e1        <= '0;
            rptr      <= 1'b0;
            wptr      <= 1'b0;
            fcount    <= 2'd0;
            local_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (enq) begin
                if (wptr) begin
                    e1 <= in_enq_v;
                end else begin
                    e0 <= in_enq_v;
                end
                wptr <= ~wptr;
            end
            if (deq) begin
                rptr <= ~rptr;
            end
            case ({enq, deq})
                2'b10:   fcount <= fcount + 2'd1;
                2'b01:   fcount <= fcount - 2'd1;
                default: fcount <= fcount;
            endcase
            if (out_enq__ENA) begin
                local_cnt <= local_cnt + 32'd1;
            end
            if (deq) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_pipe.sv
// tb_demux_pipe: directed bench for demux_pipe with immediate
// assertions at each check point and a single summary line.
module tb_demux_pipe;

    logic         clk;
    logic         rst;
    logic         in_ena;
    logic [127:0] in_v;
    logic         in_rdy;
    logic         out_ena;
    logic [127:0] out_v;
    logic         out_rdy;
    logic         fwd_ena;
    logic [127:0] fwd_v;
    logic         fwd_rdy;
    logic [31:0]  local_count;
    logic [31:0]  fwd_count;

    int total;
    int bad;

    demux_pipe #(
        .NODE_ID (8'h01),
        .DEST_HI (127)
    ) dut (
        .CLK              (clk),
        .nRST             (rst),
        .in_enq__ENA      (in_ena),
        .in_enq_v         (in_v),
        .in_enq__RDY      (in_rdy),
        .out_enq__ENA     (out_ena),
        .out_enq_v        (out_v),
        .out_enq__RDY     (out_rdy),
        .forward_enq__ENA (fwd_ena),
        .forward_enq_v    (fwd_v),
        .forward_enq__RDY (fwd_rdy),
        .localCount       (local_count),
        .fwdCount         (fwd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Sender must honour ready; flag any violation.
    always @(posedge clk) begin
        if (!rst && in_ena) begin
            total++;
            assert (in_rdy === 1'b1) else begin
                bad++;
                $error("FAIL protocol: in_ena with in_rdy %b want 1", in_rdy);
            end
        end
    end

    function automatic logic [127:0] msg(input logic [7:0] dest,
                                         input logic [7:0] pay);
        return {dest, 112'h0, pay};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        in_ena  = 1'b0;
        in_v    = '0;
        out_rdy = 1'b1;
        fwd_rdy = 1'b1;
        #3;
        chk("rst_in_rdy", 128'(in_rdy), 128'd0);
        chk("rst_fwd_ena", 128'(fwd_ena), 128'd0);
        chk("rst_out_ena", 128'(out_ena), 128'd0);
        chk("rst_lcnt", 128'(local_count), 128'd0);
        chk("rst_fcnt", 128'(fwd_count), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // local pass-through
        step();
        chk("idle_in_rdy", 128'(in_rdy), 128'd1);
        in_ena = 1'b1;
        in_v   = msg(8'h01, 8'hA5);
        #1;
        chk("loc_out_ena", 128'(out_ena), 128'd1);
        chk("loc_out_v", out_v, msg(8'h01, 8'hA5));
        chk("loc_fwd_ena", 128'(fwd_ena), 128'd0);
        step();
        in_ena = 1'b0;
        #1;
        chk("loc_lcnt", 128'(local_count), 128'd1);
        chk("loc_fcnt", 128'(fwd_count), 128'd0);

        // forward latency and ordering
        in_ena = 1'b1;
        in_v   = msg(8'h02, 8'h11);
        #1;
        chk("fwd_n_ena", 128'(fwd_ena), 128'd0);
        chk("fwd_n_out", 128'(out_ena), 128'd0);
        step();
        in_v = msg(8'h02, 8'h22);
        #1;
        chk("fwd_n1_ena", 128'(fwd_ena), 128'd1);
        chk("fwd_n1_v", fwd_v, msg(8'h02, 8'h11));
        chk("fwd_n1_rdy", 128'(in_rdy), 128'd1);
        step();
        in_ena = 1'b0;
        #1;
        chk("fwd_n2_ena", 128'(fwd_ena), 128'd1);
        chk("fwd_n2_v", fwd_v, msg(8'h02, 8'h22));
        step();
        chk("fwd_empty_ena", 128'(fwd_ena), 128'd0);
        chk("fwd_fcnt", 128'(fwd_count), 128'd2);
        chk("fwd_lcnt", 128'(local_count), 128'd1);

        // full FIFO
        fwd_rdy = 1'b0;
        in_ena  = 1'b1;
        in_v    = msg(8'h03, 8'h33);
        step();
        in_v = msg(8'h04, 8'h44);
        step();
        in_ena = 1'b0;
        #1;
        chk("full_in_rdy", 128'(in_rdy), 128'd0);
        chk("full_fwd_ena", 128'(fwd_ena), 128'd0);
        chk("full_head", fwd_v, msg(8'h03, 8'h33));
        step();
        chk("full_hold", fwd_v, msg(8'h03, 8'h33));
        fwd_rdy = 1'b1;
        #1;
        chk("full_drain_ena", 128'(fwd_ena), 128'd1);
        chk("full_drain_rdy", 128'(in_rdy), 128'd0);
        step();
        fwd_rdy = 1'b0;
        #1;
        chk("full_after_rdy", 128'(in_rdy), 128'd1);
        chk("full_after_head", fwd_v, msg(8'h04, 8'h44));
        chk("full_fcnt", 128'(fwd_count), 128'd3);
        fwd_rdy = 1'b1;
        #1;
        chk("full_last_ena", 128'(fwd_ena), 128'd1);
        step();
        fwd_rdy = 1'b0;
        #1;
        chk("drained_fcnt", 128'(fwd_count), 128'd4);
        chk("drained_ena", 128'(fwd_ena), 128'd0);

        // local backpressure stalls all input
        out_rdy = 1'b0;
        #1;
        chk("bp_in_rdy", 128'(in_rdy), 128'd0);
        step();
        chk("bp_lcnt", 128'(local_count), 128'd1);
        chk("bp_fcnt", 128'(fwd_count), 128'd4);
        chk("bp_fwd_ena", 128'(fwd_ena), 128'd0);
        out_rdy = 1'b1;

        // local counter wrap
        force dut.local_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.local_cnt;
        #1;
        chk("wrap_pre", 128'(local_count), 128'hFFFF_FFFF);
        in_ena = 1'b1;
        in_v   = msg(8'h01, 8'h5A);
        #1;
        chk("wrap_out_ena", 128'(out_ena), 128'd1);
        step();
        in_ena = 1'b0;
        #1;
        chk("wrap_lcnt", 128'(local_count), 128'd0);

        // async reset with a full FIFO
        fwd_rdy = 1'b0;
        in_ena  = 1'b1;
        in_v    = msg(8'h07, 8'h55);
        step();
        in_v = msg(8'h07, 8'h66);
        step();
        in_ena = 1'b0;
        #1;
        chk("ar_full_rdy", 128'(in_rdy), 128'd0);
        #1;
        rst = 1'b1;
        #1;
        fwd_rdy = 1'b1;
        #1;
        chk("ar_fwd_ena", 128'(fwd_ena), 128'd0);
        chk("ar_in_rdy", 128'(in_rdy), 128'd0);
        chk("ar_fcnt", 128'(fwd_count), 128'd0);
        chk("ar_lcnt", 128'(local_count), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("ar_no_stale", 128'(fwd_ena), 128'd0);
            chk("ar_post_rdy", 128'(in_rdy), 128'd1);
            @(negedge clk);
        end
        chk("ar_post_fcnt", 128'(fwd_count), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_pipe.md
# demux_pipe

Splits one 128-bit enq stream into a local output and a forward output, using the destination byte carried in the message. Local traffic passes straight through with zero latency. Forward traffic is held in a 2-entry FIFO before it is re-issued. The block is the receive-side counterpart of the merging pipe on a daisy-chained indication ring: each node takes out its own messages and passes the rest downstream.

## Interface
Parameters:
- NODE_ID, 8'h01: the destination value that selects the local port.
- DEST_HI, 127: MSB of the 8-bit destination field. The field is v[DEST_HI:DEST_HI-7].

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- nRST  input  1  reset, asynchronous and active-high: state clears immediately while nRST = 1.
- in$enq__ENA  input  1  input message valid and accepted this cycle.
- in$enq$v  input  128  input message.
- in$enq__RDY  output  1  block can accept an input message.
- out$enq__ENA  output  1  local message issued.
- out$enq$v  output  128  local message.
- out$enq__RDY  input  1  local sink ready.
- forward$enq__ENA  output  1  forward message issued.
- forward$enq$v  output  128  forward message (FIFO head).
- forward$enq__RDY  input  1  downstream ready.
- localCount  output  32  count of local messages issued.
- fwdCount  output  32  count of forward messages issued.

## Operation
- A message is local when in$enq$v[DEST_HI:DEST_HI-7] == NODE_ID. Otherwise it is forward-bound.
- in$enq__RDY = out$enq__RDY & (fcount != 2) & !nRST.
  - The ready is conservative and independent of the data, so the sender never needs to decode the destination.
- in$enq__ENA is asserted only when in$enq__RDY = 1. Behaviour on a protocol violation is undefined; the bench flags it.
- Local path, combinational:
  - out$enq__ENA = in$enq__ENA & local.
  - out$enq$v = in$enq$v.
- Forward path: a 2-entry circular FIFO.
  - State: 128-bit entries e0 and e1, 1-bit rptr and wptr, 2-bit fcount (0..2).
  - Enqueue when in$enq__ENA & !local: write e[wptr], then wptr toggles.
  - Drain rule fires when fcount != 0 & forward$enq__RDY.
  - On fire: forward$enq__ENA = 1, forward$enq$v = e[rptr], rptr toggles.
  - forward$enq$v shows e[rptr] whenever fcount != 0. Its value is don't-care when fcount = 0.
- fcount update:
  - enqueue and drain in the same cycle: unchanged (allowed only when fcount = 1);
  - enqueue only: +1;
  - drain only: -1.
- There is no bypass. A message never enters and leaves the FIFO in the same cycle.
- Counters:
  - localCount increments on out$enq__ENA.
  - fwdCount increments on forward$enq__ENA.
  - Both are 32-bit and wrap from 32'hFFFFFFFF to 0.
- Ordering: forward messages leave in arrival order. There is no ordering relation between the local and forward streams.

## Timing
- Local latency is 0 cycles: in$enq__ENA in cycle N gives out$enq__ENA in cycle N.
- Forward latency is at least 1 cycle: enqueue in cycle N, earliest forward$enq__ENA in cycle N+1.
- Forward throughput: one message per cycle in steady state, with the FIFO holding 1 entry.
- Full condition, fcount = 2:
  - in$enq__RDY = 0 even if a drain fires this cycle. Ready returns the cycle after the drain.
- Backpressure:
  - out$enq__RDY = 0 stalls all input, including forward-bound messages.
  - forward$enq__RDY = 0 holds the FIFO head stable until it drains.
- Reset, while nRST = 1 (async assert, deassert synchronous to CLK in the system):
  - fcount, rptr, wptr, e0, e1, localCount and fwdCount are all 0.
  - in$enq__RDY = 0, forward$enq__ENA = 0, out$enq__ENA = 0.
- Reset asserted mid-operation discards any queued forward messages. No partial issue occurs.

## Test plan
- Local pass-through:
  - Stimulus: enq v[127:120] = 8'h01, low bits 0xA5 with out$enq__RDY = 1.
  - Response: out$enq__ENA = 1 in the same cycle, out$enq$v equals the input, localCount = 1, fwdCount = 0.
- Forward latency and order:
  - Stimulus: enq dest 8'h02 with payloads 0x11 then 0x22 on consecutive cycles, forward$enq__RDY = 1.
  - Response: forward$enq__ENA is 1 in cycles N+1 and N+2 with 0x11 then 0x22, and fwdCount = 2.
- Full FIFO:
  - Stimulus: forward$enq__RDY = 0, enqueue 2 forward messages.
  - Response: in$enq__RDY drops to 0 after the second enqueue.
  - Stimulus: raise forward$enq__RDY for 1 cycle.
  - Response: the first message drains and in$enq__RDY = 1 on the next cycle.
- Local backpressure: with out$enq__RDY = 0 and the FIFO empty, in$enq__RDY = 0 and no state changes.
- Counter wrap: force localCount to 32'hFFFFFFFF, then issue one local message → localCount = 0.
- Async reset:
  - Stimulus: assert nRST between clock edges with fcount = 2.
  - Response: immediately fcount = 0, forward$enq__ENA = 0 and in$enq__RDY = 0. After release, no stale forward message is ever issued.
